// File: rtl/stall_mon_pkg.sv
// stall_mon_pkg: shared state encoding and saturating counter helper for the stall monitor.
package stall_mon_pkg;
  typedef enum logic [1:0] {IDLE, WATCH, BLOCKED} stall_state_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/stall_prio_enc.sv
// stall_prio_enc: combinational lowest-set-bit encoder with a valid flag.
module stall_prio_enc #(
  parameter int NUM_SIGS = 12,
  parameter int IDX_W    = (NUM_SIGS > 1) ? $clog2(NUM_SIGS) : 1
) (
  input  logic [NUM_SIGS-1:0] sigs_i,
  output logic [IDX_W-1:0]    idx_o,
  output logic                valid_o
);
  always_comb begin
    idx_o = '0;
    for (int i = NUM_SIGS - 1; i >= 0; i--)
      if (sigs_i[i]) idx_o = IDX_W'(i);
  end
  assign valid_o = |sigs_i;
endmodule

// File: rtl/axis_stall_monitor.sv
// axis_stall_monitor: raises block after a masked stall persists THRESH cycles and reports its source channel.
module axis_stall_monitor
  import stall_mon_pkg::*;
#(
  parameter int                  NUM_SIGS   = 12,
  parameter logic [NUM_SIGS-1:0] WATCH_MASK = 12'hF00,
  parameter int                  THRESH     = 1,
  parameter int                  CNT_W      = 16,
  parameter bit                  STICKY     = 1'b0,
  parameter int                  IDX_W      = (NUM_SIGS > 1) ? $clog2(NUM_SIGS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_SIGS-1:0] axis_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic [IDX_W-1:0]    block_src,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    event_cnt
);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
  stall_state_t state_q, state_d;
  logic block_q, block_d, any;
  logic [IDX_W-1:0] src_q, src_d, first_idx;
  logic [CNT_W-1:0] stall_q, stall_d, event_q, event_d, run_next, event_next;
  logic hit;
  stall_prio_enc #(.NUM_SIGS(NUM_SIGS), .IDX_W(IDX_W)) u_enc (
    .sigs_i (axis_block_sigs & WATCH_MASK),
    .idx_o  (first_idx),
    .valid_o(any)
  );
  assign run_next   = CNT_W'(sat_inc(32'(stall_q), CNT_MAX));
  assign event_next = CNT_W'(sat_inc(32'(event_q), CNT_MAX));
  assign hit        = 32'(run_next) >= 32'(THRESH);
  always_comb begin
    state_d = state_q;
    block_d = block_q;
    src_d   = src_q;
    stall_d = any ? run_next : '0;
    event_d = event_q;
    if (clear) begin
      state_d = IDLE;
      block_d = 1'b0;
      src_d   = '0;
      stall_d = '0;
      event_d = '0;
    end else if (state_q != BLOCKED) begin
      state_d = !any ? IDLE : hit ? BLOCKED : WATCH;
      if (any && hit) begin
        block_d = 1'b1;
        src_d   = first_idx;
        event_d = event_next;
      end
    end else if (!any && !STICKY) begin
      state_d = IDLE;
      block_d = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      block_q <= 1'b0;
      src_q   <= '0;
      stall_q <= '0;
      event_q <= '0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      src_q   <= src_d;
      stall_q <= stall_d;
      event_q <= event_d;
    end
  end
  assign block     = block_q;
  assign block_src = src_q;
  assign stall_cnt = stall_q;
  assign event_cnt = event_q;
endmodule

// File: tb/tb_axis_stall_monitor.sv
// tb_axis_stall_monitor: three monitor configurations checked cycle by cycle against a behavioural scoreboard.
module tb_axis_stall_monitor;
  logic clock = 1'b0, reset = 1'b1, clear = 1'b0;
  logic [11:0] sigs = '0;
  int n_checks = 0, n_fail = 0;
  always #5 clock = ~clock;
  logic ob[3];
  logic [3:0] os[3];
  logic [15:0] osc[3], oec[3];
  logic [2:0] sc2, ec2;
  axis_stall_monitor #(.THRESH(4)) u_d0 (.clock(clock), .reset(reset), .axis_block_sigs(sigs), .clear(clear),
    .block(ob[0]), .block_src(os[0]), .stall_cnt(osc[0]), .event_cnt(oec[0]));
  axis_stall_monitor #(.THRESH(4), .STICKY(1'b1)) u_d1 (.clock(clock), .reset(reset), .axis_block_sigs(sigs), .clear(clear),
    .block(ob[1]), .block_src(os[1]), .stall_cnt(osc[1]), .event_cnt(oec[1]));
  axis_stall_monitor #(.THRESH(2), .CNT_W(3)) u_d2 (.clock(clock), .reset(reset), .axis_block_sigs(sigs), .clear(clear),
    .block(ob[2]), .block_src(os[2]), .stall_cnt(sc2), .event_cnt(ec2));
  assign osc[2] = {13'd0, sc2};
  assign oec[2] = {13'd0, ec2};
  typedef struct {
    logic b[3];
    logic [3:0] s[3];
    logic [15:0] sc[3];
    logic [15:0] ec[3];
  } exp_t;
  exp_t sb[$];
  int th[3] = '{4, 4, 2};
  int mx[3] = '{65535, 65535, 7};
  bit st[3] = '{1'b0, 1'b1, 1'b0};
  int m_run[3], m_ev[3], m_src[3];
  bit m_blk[3];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int lowest(input logic [11:0] v);
    for (int i = 0; i < 12; i++) if (v[i]) return i;
    return 0;
  endfunction
  task automatic step(input logic [11:0] s, input logic c = 1'b0, input logic r = 1'b0);
    exp_t e;
    logic [11:0] m;
    sigs = s; clear = c; reset = r;
    m = s & 12'hF00;
    for (int k = 0; k < 3; k++) begin
      if (r || c) begin
        m_run[k] = 0; m_ev[k] = 0; m_src[k] = 0; m_blk[k] = 1'b0;
      end else if (m != 0) begin
        if (m_run[k] < mx[k]) m_run[k]++;
        if (!m_blk[k] && m_run[k] >= th[k]) begin
          m_blk[k] = 1'b1;
          m_src[k] = lowest(m);
          if (m_ev[k] < mx[k]) m_ev[k]++;
        end
      end else begin
        m_run[k] = 0;
        if (!st[k]) m_blk[k] = 1'b0;
      end
      e.b[k] = m_blk[k]; e.s[k] = 4'(m_src[k]); e.sc[k] = 16'(m_run[k]); e.ec[k] = 16'(m_ev[k]);
    end
    sb.push_back(e);
    @(posedge clock); #1;
    if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
        check($sformatf("d%0d_block", k), 32'(ob[k]), 32'(e.b[k]));
        check($sformatf("d%0d_src", k), 32'(os[k]), 32'(e.s[k]));
        check($sformatf("d%0d_stall", k), 32'(osc[k]), 32'(e.sc[k]));
        check($sformatf("d%0d_event", k), 32'(oec[k]), 32'(e.ec[k]));
      end
    end
  endtask
  initial begin
    int peak;
    step(12'h000, 1'b0, 1'b1);
    step(12'h000, 1'b0, 1'b1);
    check("rst_block", 32'(ob[0]), 32'd0);
    check("rst_stall", 32'(osc[0]), 32'd0);
    // threshold: bit 9 for five cycles
    for (int i = 1; i <= 5; i++) begin
      step(12'h200);
      if (i == 3) check("thr_pre_block", 32'(ob[0]), 32'd0);
      if (i == 4) check("thr_block_rise", 32'(ob[0]), 32'd1);
    end
    check("thr_src", 32'(os[0]), 32'd9);
    check("thr_event", 32'(oec[0]), 32'd1);
    check("thr_stall", 32'(osc[0]), 32'd5);
    step(12'h000);
    check("thr_block_fall", 32'(ob[0]), 32'd0);
    check("thr_src_hold", 32'(os[0]), 32'd9);
    // gap resets the run
    peak = 0;
    for (int i = 0; i < 7; i++) begin
      step(i == 3 ? 12'h000 : 12'h200);
      check("gap_block", 32'(ob[0]), 32'd0);
      if (int'(osc[0]) > peak) peak = int'(osc[0]);
    end
    check("gap_peak", 32'(peak), 32'd3);
    step(12'h000, 1'b1);
    for (int i = 0; i < 100; i++) step(12'h004);
    check("unmasked_block", 32'(ob[0]), 32'd0);
    check("unmasked_stall", 32'(osc[0]), 32'd0);
    check("unmasked_event", 32'(oec[0]), 32'd0);
    for (int i = 0; i < 4; i++) step(12'h900);
    check("prio_src", 32'(os[0]), 32'd8);
    check("prio_block", 32'(ob[0]), 32'd1);
    // sticky configuration
    step(12'h000, 1'b1);
    for (int i = 0; i < 4; i++) step(12'h400);
    for (int i = 0; i < 20; i++) step(12'h000);
    check("sticky_block", 32'(ob[1]), 32'd1);
    check("sticky_stall", 32'(osc[1]), 32'd0);
    check("sticky_src", 32'(os[1]), 32'd10);
    for (int i = 0; i < 4; i++) step(12'h100);
    check("sticky_no_reevent", 32'(oec[1]), 32'd1);
    check("sticky_no_recapture", 32'(os[1]), 32'd10);
    step(12'h000, 1'b1);
    check("sticky_clr_block", 32'(ob[1]), 32'd0);
    check("sticky_clr_event", 32'(oec[1]), 32'd0);
    check("sticky_clr_src", 32'(os[1]), 32'd0);
    // saturation on the narrow-counter configuration
    for (int i = 0; i < 20; i++) step(12'h100);
    check("sat_stall", 32'(osc[2]), 32'd7);
    step(12'h000, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(12'h100); step(12'h100); step(12'h000);
    end
    check("sat_event", 32'(oec[2]), 32'd7);
    // reset and clear priority
    for (int i = 0; i < 5; i++) step(12'h200);
    check("pre_rst_block", 32'(ob[0]), 32'd1);
    step(12'h200, 1'b0, 1'b1);
    check("rst_mid_block", 32'(ob[0]), 32'd0);
    check("rst_mid_src", 32'(os[0]), 32'd0);
    check("rst_mid_stall", 32'(osc[0]), 32'd0);
    check("rst_mid_event", 32'(oec[0]), 32'd0);
    step(12'h200, 1'b1);
    check("clr_stall0", 32'(osc[0]), 32'd0);
    step(12'h200);
    check("clr_stall1", 32'(osc[0]), 32'd1);
    for (int i = 0; i < 300; i++)
      step(12'($urandom) & (($urandom_range(0, 3) == 0) ? 12'h0FF : 12'hFFF), $urandom_range(0, 29) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_stall_monitor.md
# axis_stall_monitor

Parametrised stall/deadlock monitor for HLS co-simulation benches: watches a vector of per-channel AXI-Stream block indications, raises `block` only after a qualifying stall has persisted for a programmable number of cycles, and reports which channel caused it. It is the next generation of the per-instance deadlock monitors attached to pipeline loops such as the PFB `write_outputs` write loop. It adds:

- a channel mask
- a persistence threshold
- a sticky mode
- offender capture
- run and event counters

## Interface

Parameters:

- `NUM_SIGS`, 12: width of the watched block-signal vector.
- `WATCH_MASK`, 12'hF00: per-bit enable. Only set bits participate.
- `THRESH`, 1: consecutive stalled cycles required to assert `block`. Legal range 1..2^CNT_W−1.
- `CNT_W`, 16: width of both counters.
- `STICKY`, 0: 0 means `block` drops when the stall clears. 1 means `block` is held until `clear`.
- `IDX_W`, $clog2(NUM_SIGS): width of `block_src`. Minimum 1.

Ports:

- `clock`: input, 1 bit. The clock.
- `reset`: input, 1 bit. Synchronous, active-high reset.
- `axis_block_sigs`: input, NUM_SIGS bits. Per-channel block indications, sampled every edge.
- `clear`: input, 1 bit. Synchronous soft clear of state, counters and flags.
- `block`: output, 1 bit. Qualified stall detected.
- `block_src`: output, IDX_W bits. Lowest masked channel index active at the edge where `block` was raised.
- `stall_cnt`: output, CNT_W bits. Current consecutive-stall run length, saturating.
- `event_cnt`: output, CNT_W bits. Number of entries into BLOCKED, saturating.

## Operation

- Stall detection: `masked = axis_block_sigs & WATCH_MASK`; `any = |masked`.
- FSM states:
  - IDLE, reset state.
  - WATCH, counting a stall run.
  - BLOCKED.
- Update priority each edge: `reset` > `clear` > FSM update.
- IDLE or WATCH with `any`=1:
  - `run_next = sat(stall_cnt + 1)`.
  - If `run_next >= THRESH`: go to BLOCKED, set `block`=1, capture `block_src` = lowest set index of `masked`, and increment `event_cnt` (saturating).
  - Otherwise: go to WATCH.
  - `stall_cnt` takes `run_next` in both cases.
- IDLE or WATCH with `any`=0: go to IDLE, `stall_cnt` = 0.
- BLOCKED with `any`=1: stay in BLOCKED. `stall_cnt` keeps saturating-incrementing. `block_src` holds.
- BLOCKED with `any`=0:
  - `stall_cnt` = 0.
  - STICKY=0: go to IDLE, `block`=0.
  - STICKY=1: stay in BLOCKED with `block` held. A new stall run does not re-increment `event_cnt` and does not recapture `block_src`.
- `clear`: go to IDLE. Zero `block`, `stall_cnt`, `event_cnt` and `block_src`. If `clear` and `any` occur on the same edge, the clear wins and counting restarts on the next edge.
- `block_src` holds its value after `block` drops (STICKY=0) until the next entry into BLOCKED.
- Saturation: both counters stop at 2^CNT_W−1 and never wrap.
- Unmasked channels have no effect on any output.

## Timing

- All outputs are registered. Reset and clear values: `block`=0, `block_src`=0, `stall_cnt`=0, `event_cnt`=0, state=IDLE.
- Latency: a stall first sampled at edge k sets `block` after edge k+THRESH−1.
  - THRESH=1: `block` is high the cycle after the first stalled sample. This is identical to the previous single-cycle monitor.
- Drop (STICKY=0): `block` falls one edge after the first sample with `any`=0.
- A single-cycle gap in the stall resets the run. Runs are strictly consecutive.
- Reset mid-run or while BLOCKED: all state clears on that edge. No partial counts survive.

## Structure

- Package `stall_mon_pkg`:
  - state enum `stall_state_t` {IDLE, WATCH, BLOCKED}.
  - saturating-increment function `sat_inc`.
- Sub-module `stall_prio_enc`, parametrised on NUM_SIGS:
  - combinational lowest-set-bit encoder producing the index and a `valid` bit.
  - instantiated once on `masked`.
- One FSM process plus counter and capture registers in `axis_stall_monitor`. The target is roughly 150–200 lines total.

## Test plan

Unless a scenario states otherwise, parameters are defaults with THRESH=4.

- Threshold: hold bit 9 high for 5 cycles.
  - `block` rises after the 4th stalled edge.
  - `block_src`=9, `event_cnt`=1, `stall_cnt`=5 at the end.
  - `block` falls one edge after bit 9 drops.
- Gap and mask:
  - Bit 9 high for 3 cycles, low 1 cycle, high 3 cycles: `block` never rises and `stall_cnt` peaks at 3.
  - Bit 2 (unmasked) held for 100 cycles: no effect on any output.
- Priority capture: assert bits 11 and 8 together for 4 cycles → `block_src`=8.
- Sticky (STICKY=1):
  - Bit 10 for 4 cycles, then idle for 20 cycles: `block` stays 1 and `stall_cnt`=0.
  - Pulse `clear`: next edge gives `block`=0, `event_cnt`=0, `block_src`=0.
- Saturation (CNT_W=3, THRESH=2):
  - Hold bit 8 for 20 cycles: `stall_cnt` stops at 7.
  - 9 separate 2-cycle stalls with idle gaps: `event_cnt` stops at 7.
- Reset and clear priority:
  - Assert `reset` while BLOCKED: all outputs 0 on the next cycle.
  - Assert `clear` together with an active stall: `stall_cnt`=0 that cycle, then 1 on the following edge.
